sdram_burst_scheduler: RTL



---
 rtl/sdram_burst_scheduler.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_burst_scheduler.sv
// Arbitrates the full-page SDRAM controller between the sobel write FIFO and the VGA read FIFO.
// Define SDRAM_SCHED_DBUF_EN for double-buffered frame addressing (default: single buffer).
module sdram_burst_scheduler #(
   parameter int unsigned ADDR_W          = 15,
   parameter int unsigned CNT_W           = 10,
   parameter int unsigned BURST_LEN       = 512,
   parameter int unsigned PAGES_PER_FRAME = 600,
   parameter int unsigned RD_LOW_WM       = 250,
   parameter int unsigned MAX_WR_RUN      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [CNT_W-1:0]  wr_level,
   input  logic [CNT_W-1:0]  rd_level,
   input  logic              ctrl_ready,
   output logic              ctrl_rw_en,
   output logic              ctrl_rw,
   output logic [ADDR_W-1:0] ctrl_addr,
   output logic              wr_frame_done,
   output logic              rd_frame_done,
   output logic              busy
);

   localparam int unsigned PageW = $clog2(PAGES_PER_FRAME);
   localparam int unsigned RunW  = $clog2(MAX_WR_RUN + 1);

   localparam logic [PageW-1:0] LastPage  = PageW'(PAGES_PER_FRAME - 1);
   localparam logic [CNT_W-1:0] BurstThr  = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0] RdLowThr  = CNT_W'(RD_LOW_WM);
   localparam logic [RunW-1:0]  RunMax    = RunW'(MAX_WR_RUN);
   localparam logic [1:0]       WaitLoMax = 2'd3;

   localparam logic [2:0] StPrime  = 3'd0;
   localparam logic [2:0] StArb    = 3'd1;
   localparam logic [2:0] StIssue  = 3'd2;
   localparam logic [2:0] StWaitLo = 3'd3;
   localparam logic [2:0] StWaitHi = 3'd4;

   logic [2:0]        state_q, state_d;
   logic              primed_q, primed_d;
   logic [PageW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PageW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [RunW-1:0]   wr_run_q, wr_run_d;
   logic [1:0]        wait_cnt_q, wait_cnt_d;
   logic              gnt_rd_q, gnt_rd_d;
   logic              rw_en_q, rw_en_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wfd_q, wfd_d;
   logic              rfd_q, rfd_d;
   logic              busy_q, busy_d;

`ifdef SDRAM_SCHED_DBUF_EN
   localparam logic [ADDR_W-1:0] FrameOfs = ADDR_W'(PAGES_PER_FRAME);
   logic              wr_buf_q, wr_buf_d;
   logic              rd_buf_q, rd_buf_d;
`endif

   logic wreq, rreq, grant_wr;

   function automatic logic [PageW-1:0] next_page(input logic [PageW-1:0] p);
      return (p == LastPage) ? '0 : p + PageW'(1);
   endfunction

   assign wreq     = (wr_level >= BurstThr);
   assign rreq     = primed_q && (rd_level < RdLowThr);
   // A pending read only wins once the write run has hit its cap.
   assign grant_wr = wreq && !(rreq && (wr_run_q == RunMax));

   always_comb begin
      state_d    = state_q;
      primed_d   = primed_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      wr_run_d   = wr_run_q;
      wait_cnt_d = wait_cnt_q;
      gnt_rd_d   = gnt_rd_q;
      rw_en_d    = 1'b0;
      rw_d       = rw_q;
      addr_d     = addr_q;
      wfd_d      = 1'b0;
      rfd_d      = 1'b0;
`ifdef SDRAM_SCHED_DBUF_EN
      wr_buf_d   = wr_buf_q;
      rd_buf_d   = rd_buf_q;
`endif

      case (state_q)
         StPrime: begin
            if (enable && ctrl_ready && wreq) begin
               gnt_rd_d = 1'b0;
               primed_d = 1'b1;
               wr_run_d = '0;
               state_d  = StIssue;
            end
         end

         StArb: begin
            if (enable && ctrl_ready) begin
               if (grant_wr) begin
                  gnt_rd_d = 1'b0;
                  state_d  = StIssue;
                  if (!rreq) begin
                     wr_run_d = '0;
                  end else if (wr_run_q != RunMax) begin
                     wr_run_d = wr_run_q + RunW'(1);
                  end
               end else if (rreq) begin
                  gnt_rd_d = 1'b1;
                  wr_run_d = '0;
                  state_d  = StIssue;
               end
            end
         end

         StIssue: begin
            rw_en_d    = 1'b1;
            rw_d       = gnt_rd_q;
            wait_cnt_d = '0;
            state_d    = StWaitLo;
            if (gnt_rd_q) begin
               addr_d   = ADDR_W'(rd_ptr_q);
               rfd_d    = (rd_ptr_q == LastPage);
               rd_ptr_d = next_page(rd_ptr_q);
`ifdef SDRAM_SCHED_DBUF_EN
               if (rd_buf_q) addr_d = ADDR_W'(rd_ptr_q) + FrameOfs;
               // Read side follows the most recently completed write frame.
               if (rd_ptr_q == LastPage) rd_buf_d = ~wr_buf_q;
`endif
            end else begin
               addr_d   = ADDR_W'(wr_ptr_q);
               wfd_d    = (wr_ptr_q == LastPage);
               wr_ptr_d = next_page(wr_ptr_q);
`ifdef SDRAM_SCHED_DBUF_EN
               if (wr_buf_q) addr_d = ADDR_W'(wr_ptr_q) + FrameOfs;
               if (wr_ptr_q == LastPage) wr_buf_d = ~wr_buf_q;
`endif
            end
         end

         StWaitLo: begin
            // Guard against a controller that never drops ready for this command.
            if (!ctrl_ready) begin
               state_d = StWaitHi;
            end else if (wait_cnt_q == WaitLoMax) begin
               state_d = StArb;
            end else begin
               wait_cnt_d = wait_cnt_q + 2'd1;
            end
         end

         StWaitHi: begin
            if (ctrl_ready) state_d = StArb;
         end

         default: state_d = StPrime;
      endcase

      busy_d = (state_d == StIssue) || (state_d == StWaitLo) || (state_d == StWaitHi);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StPrime;
         primed_q   <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         wr_run_q   <= '0;
         wait_cnt_q <= '0;
         gnt_rd_q   <= 1'b0;
         rw_en_q    <= 1'b0;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         wfd_q      <= 1'b0;
         rfd_q      <= 1'b0;
         busy_q     <= 1'b0;
`ifdef SDRAM_SCHED_DBUF_EN
         wr_buf_q   <= 1'b0;
         rd_buf_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         primed_q   <= primed_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_run_q   <= wr_run_d;
         wait_cnt_q <= wait_cnt_d;
         gnt_rd_q   <= gnt_rd_d;
         rw_en_q    <= rw_en_d;
         rw_q       <= rw_d;
         addr_q     <= addr_d;
         wfd_q      <= wfd_d;
         rfd_q      <= rfd_d;
         busy_q     <= busy_d;
`ifdef SDRAM_SCHED_DBUF_EN
         wr_buf_q   <= wr_buf_d;
         rd_buf_q   <= rd_buf_d;
`endif
      end
   end

   assign ctrl_rw_en    = rw_en_q;
   assign ctrl_rw       = rw_q;
   assign ctrl_addr     = addr_q;
   assign wr_frame_done = wfd_q;
   assign rd_frame_done = rfd_q;
   assign busy          = busy_q;

   a_rw_en_gap: assert property (@(posedge clk) disable iff (!rst_n)
      ctrl_rw_en |=> !ctrl_rw_en [*2]);
   a_wfd_with_cmd: assert property (@(posedge clk) disable iff (!rst_n)
      wr_frame_done |-> (ctrl_rw_en && !ctrl_rw));
   a_rfd_with_cmd: assert property (@(posedge clk) disable iff (!rst_n)
      rd_frame_done |-> (ctrl_rw_en && ctrl_rw));

endmodule
